envelope_scheduler: RTL and testbench

ENVELOPE_SCHEDULER -- requirements
Module: envelope_scheduler

---
 rtl/envelope_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_envelope_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_scheduler.sv
// Envelope scheduler: walks every voice once per sample tick, advancing its
// attack/decay/sustain/release stage machine and emitting the voice's new gain.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 4
`endif

module envelope_scheduler #(
  parameter int N_OSC   = `N_OSCILLATORS,
  parameter int ENV_LEN = `ENVELOPE_LEN,
  localparam int VW     = (N_OSC > 1) ? $clog2(N_OSC) : 1,
  localparam int SW     = $clog2(ENV_LEN)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sample_tick,
  output logic [VW-1:0] cfg_voice,
  output logic [SW-1:0] cfg_stage,
  input  logic [31:0]   cfg_gain,
  input  logic [31:0]   cfg_duration,
  input  logic          cfg_gate,
  output logic          gain_valid,
  output logic [VW-1:0] gain_voice,
  output logic [31:0]   gain_out,
  output logic          busy,
  output logic          overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  localparam logic [SW-1:0] STG_REL  = SW'(ENV_LEN - 1);
  localparam logic [SW-1:0] STG_SUS  = SW'(ENV_LEN - 2);
  localparam logic [VW-1:0] V_LAST   = VW'(N_OSC - 1);
  localparam logic [31:0]   CNT_MAX  = 32'hFFFF_FFFF;

  logic [1:0]    state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic [VW-1:0] v_inc_s;
  logic          run_q;
  logic [VW-1:0] cfg_voice_q, cfg_voice_d;
  logic [SW-1:0] cfg_stage_q, cfg_stage_d;
  logic [31:0]   gain_q, dur_q;
  logic          gate_q;
  logic          gain_valid_q, gain_valid_d;
  logic [VW-1:0] gain_voice_q, gain_voice_d;
  logic [31:0]   gain_out_q, gain_out_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          upd_en_s;

  logic          active_q    [N_OSC];
  logic [SW-1:0] stage_q     [N_OSC];
  logic [31:0]   count_q     [N_OSC];
  logic          prev_gate_q [N_OSC];

  logic          cur_act_s, cur_pg_s, nxt_act_s, expire_s;
  logic [SW-1:0] cur_stg_s, nxt_stg_s;
  logic [31:0]   cur_cnt_s, nxt_cnt_s, cnt_inc_s, dur_eff_s;

  assign v_inc_s = v_q + VW'(1);

  // Envelope rules for the voice currently in UPDATE
  always_comb begin
    cur_act_s = active_q[v_q];
    cur_stg_s = stage_q[v_q];
    cur_cnt_s = count_q[v_q];
    cur_pg_s  = prev_gate_q[v_q];
    dur_eff_s = (dur_q == 32'd0) ? 32'd1 : dur_q;
    cnt_inc_s = (cur_cnt_s == CNT_MAX) ? cur_cnt_s : cur_cnt_s + 32'd1;
    expire_s  = (cnt_inc_s >= dur_eff_s);
    nxt_act_s = cur_act_s;
    nxt_stg_s = cur_stg_s;
    nxt_cnt_s = cur_cnt_s;
    if (gate_q && !cur_pg_s) begin
      nxt_act_s = 1'b1;
      nxt_stg_s = '0;
      nxt_cnt_s = 32'd0;
    end else if (!gate_q && cur_pg_s && cur_act_s) begin
      nxt_stg_s = STG_REL;
      nxt_cnt_s = 32'd0;
    end else if (cur_act_s && (cur_stg_s == STG_REL)) begin
      if (expire_s) begin
        nxt_act_s = 1'b0;
        nxt_stg_s = '0;
        nxt_cnt_s = 32'd0;
      end else begin
        nxt_cnt_s = cnt_inc_s;
      end
    end else if (cur_act_s && gate_q && (cur_stg_s < STG_SUS)) begin
      if (expire_s) begin
        nxt_stg_s = cur_stg_s + SW'(1);
        nxt_cnt_s = 32'd0;
      end else begin
        nxt_cnt_s = cnt_inc_s;
      end
    end else begin
      nxt_act_s = cur_act_s;
    end
  end

  // Pass sequencing, output strobe and overrun detection
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    cfg_voice_d  = cfg_voice_q;
    cfg_stage_d  = cfg_stage_q;
    gain_valid_d = 1'b0;
    gain_voice_d = gain_voice_q;
    gain_out_d   = gain_out_q;
    upd_en_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_tick && run_q) begin
          state_d     = S_READ;
          v_d         = '0;
          cfg_voice_d = '0;
          cfg_stage_d = stage_q[0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        upd_en_s     = 1'b1;
        gain_valid_d = 1'b1;
        gain_voice_d = v_q;
        gain_out_d   = nxt_act_s ? gain_q : 32'd0;
        if (v_q == V_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_READ;
          v_d         = v_inc_s;
          cfg_voice_d = v_inc_s;
          cfg_stage_d = stage_q[v_inc_s];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A tick that lands on any non-idle cycle, including the last UPDATE, is lost
    if (sample_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      v_q          <= '0;
      cfg_voice_q  <= '0;
      cfg_stage_q  <= '0;
      gain_valid_q <= 1'b0;
      gain_voice_q <= '0;
      gain_out_q   <= 32'd0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      cfg_voice_q  <= cfg_voice_d;
      cfg_stage_q  <= cfg_stage_d;
      gain_valid_q <= gain_valid_d;
      gain_voice_q <= gain_voice_d;
      gain_out_q   <= gain_out_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Ticks are accepted only once this flag has seen one edge out of reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Capture of the configuration table entry addressed during READ
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gain_q <= 32'd0;
      dur_q  <= 32'd0;
      gate_q <= 1'b0;
    end else if (state_q == S_READ) begin
      gain_q <= cfg_gain;
      dur_q  <= cfg_duration;
      gate_q <= cfg_gate;
    end else begin
      gain_q <= gain_q;
      dur_q  <= dur_q;
      gate_q <= gate_q;
    end
  end

  // Per-voice envelope state, written back only for the voice in UPDATE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_OSC; i++) begin
        active_q[i]    <= 1'b0;
        stage_q[i]     <= '0;
        count_q[i]     <= 32'd0;
        prev_gate_q[i] <= 1'b0;
      end
    end else if (upd_en_s) begin
      active_q[v_q]    <= nxt_act_s;
      stage_q[v_q]     <= nxt_stg_s;
      count_q[v_q]     <= nxt_cnt_s;
      prev_gate_q[v_q] <= gate_q;
    end
  end

  assign cfg_voice  = cfg_voice_q;
  assign cfg_stage  = cfg_stage_q;
  assign gain_valid = gain_valid_q;
  assign gain_voice = gain_voice_q;
  assign gain_out   = gain_out_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_envelope_scheduler.sv
// Self-checking bench for envelope_scheduler: directed scenarios plus random
// gate/duration/gain traffic against a per-voice envelope model.
module tb_envelope_scheduler;
  localparam int N = 4;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sample_tick;
  logic [1:0]  cfg_voice;
  logic [1:0]  cfg_stage;
  logic [31:0] cfg_gain;
  logic [31:0] cfg_duration;
  logic        cfg_gate;
  logic        gain_valid;
  logic [1:0]  gain_voice;
  logic [31:0] gain_out;
  logic        busy;
  logic        overrun;

  logic [31:0] gain_tab [N][L];
  logic [31:0] dur_tab  [N][L];
  logic        gate_tab [N];

  int checks = 0;
  int errors = 0;

  int              m_act [N];
  int              m_stg [N];
  longint unsigned m_cnt [N];
  int              m_pg  [N];
  logic            m_ovr;

  envelope_scheduler #(.N_OSC(N), .ENV_LEN(L)) dut (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick),
    .cfg_voice(cfg_voice), .cfg_stage(cfg_stage),
    .cfg_gain(cfg_gain), .cfg_duration(cfg_duration), .cfg_gate(cfg_gate),
    .gain_valid(gain_valid), .gain_voice(gain_voice), .gain_out(gain_out),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Voice configuration table seen by the scheduler
  always_comb begin
    cfg_gain     = gain_tab[cfg_voice][cfg_stage];
    cfg_duration = dur_tab[cfg_voice][cfg_stage];
    cfg_gate     = gate_tab[cfg_voice];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_act[v] = 0; m_stg[v] = 0; m_cnt[v] = 0; m_pg[v] = 0;
    end
    m_ovr = 1'b0;
  endtask

  // One tick's worth of envelope rules for voice v; returns the gain it should emit
  task automatic model_step(input int v, output logic [31:0] eg);
    longint unsigned d;
    int rd;
    logic g;
    g  = gate_tab[v];
    rd = m_stg[v];
    d  = longint'(dur_tab[v][rd]);
    if (d == 0) d = 1;
    if (g && m_pg[v] == 0) begin
      m_act[v] = 1; m_stg[v] = 0; m_cnt[v] = 0;
    end else if (!g && m_pg[v] == 1 && m_act[v] == 1) begin
      m_stg[v] = L - 1; m_cnt[v] = 0;
    end else if (m_act[v] == 1 && (m_stg[v] == L - 1 || (g && m_stg[v] < L - 2))) begin
      if (m_cnt[v] < 64'hFFFF_FFFF) m_cnt[v] = m_cnt[v] + 1;
      if (m_cnt[v] >= d) begin
        m_cnt[v] = 0;
        if (m_stg[v] == L - 1) begin
          m_act[v] = 0; m_stg[v] = 0;
        end else begin
          m_stg[v] = m_stg[v] + 1;
        end
      end
    end
    m_pg[v] = g ? 1 : 0;
    eg = (m_act[v] == 1) ? gain_tab[v][rd] : 32'd0;
  endtask

  // One full pass; extra_at >= 0 injects a second tick into cycle extra_at+1
  task automatic run_pass(input int extra_at);
    logic [31:0] eg [N];
    int ps [N];
    for (int v = 0; v < N; v++) ps[v] = m_stg[v];
    for (int v = 0; v < N; v++) model_step(v, eg[v]);
    if (extra_at >= 0) m_ovr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("busy", 64'(busy), 64'(k <= 2 * N - 1));
      chk("gain_valid", 64'(gain_valid), 64'(k >= 2 && k <= 2 * N && k % 2 == 0));
      if (k >= 2 && k <= 2 * N && k % 2 == 0) begin
        chk("gain_voice", 64'(gain_voice), 64'((k - 2) / 2));
        chk("gain_out", 64'(gain_out), 64'(eg[(k - 2) / 2]));
      end
      if (k < 2 * N && k % 2 == 0) begin
        chk("cfg_voice", 64'(cfg_voice), 64'(k / 2));
        chk("cfg_stage", 64'(cfg_stage), 64'(ps[k / 2]));
      end
      if (k >= 2 * N) begin
        chk("cfg_voice_hold", 64'(cfg_voice), 64'(N - 1));
        chk("cfg_stage_hold", 64'(cfg_stage), 64'(ps[N - 1]));
      end
      sample_tick = (k == extra_at);
      @(posedge clk); #1;
    end
    sample_tick = 1'b0;
    chk("overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gain_valid"}, 64'(gain_valid), 64'd0);
    chk({tag, "_gain_voice"}, 64'(gain_voice), 64'd0);
    chk({tag, "_gain_out"}, 64'(gain_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_cfg_voice"}, 64'(cfg_voice), 64'd0);
    chk({tag, "_cfg_stage"}, 64'(cfg_stage), 64'd0);
  endtask

  initial begin
    logic [31:0] dummy;
    rstn = 1'b0;
    sample_tick = 1'b0;
    for (int v = 0; v < N; v++) begin
      gate_tab[v] = 1'b0;
      for (int s = 0; s < L; s++) begin
        gain_tab[v][s] = 32'h100 * (v + 1) + s + 1;
        dur_tab[v][s]  = 32'd2;
      end
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Tick held across deassertion: ignored on 1st edge, honored on 2nd
    @(negedge clk);
    rstn = 1'b1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    chk("tick_edge1_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    chk("tick_edge2_busy", 64'(busy), 64'd1);
    chk("tick_edge2_overrun", 64'(overrun), 64'd0);
    for (int v = 0; v < N; v++) model_step(v, dummy);
    repeat (12) @(posedge clk);
    #1;

    // All gates low: four zero-gain strobes
    run_pass(-1);

    // Attack, decay into sustain, then hold
    gain_tab[0][0] = 32'hA; gain_tab[0][1] = 32'hB;
    gain_tab[0][2] = 32'h5; gain_tab[0][3] = 32'hE;
    dur_tab[0][0] = 32'd2; dur_tab[0][1] = 32'd3;
    dur_tab[0][2] = 32'd7; dur_tab[0][3] = 32'd5;
    gate_tab[0] = 1'b1;
    repeat (10) run_pass(-1);

    // Release to silence, then restart on a new rising gate
    gate_tab[0] = 1'b0;
    repeat (7) run_pass(-1);
    gate_tab[0] = 1'b1;
    repeat (4) run_pass(-1);

    // Retrigger from stage 1 via release
    gate_tab[0] = 1'b0;
    run_pass(-1);
    gate_tab[0] = 1'b1;
    repeat (3) run_pass(-1);

    // Overrun: second tick three cycles after the first
    run_pass(2);

    // Reset during voice 2 of a pass
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_gain_valid", 64'(gain_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk_all_zero("midpass_reset");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet_valid", 64'(gain_valid), 64'd0);
      chk("post_reset_quiet_busy", 64'(busy), 64'd0);
    end
    run_pass(-1);

    // Overrun from a tick on the final UPDATE cycle
    run_pass(2 * N - 1);

    // Random traffic
    for (int p = 0; p < 40; p++) begin
      for (int v = 0; v < N; v++) begin
        if ($urandom_range(0, 3) == 0) gate_tab[v] = ~gate_tab[v];
        for (int s = 0; s < L; s++) begin
          gain_tab[v][s] = $urandom;
          dur_tab[v][s]  = 32'($urandom_range(0, 4));
        end
      end
      run_pass(($urandom_range(0, 9) == 0) ? 5 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
